// File: rtl/pixie_pkg.sv
// pixie_pkg: Studio II display constants and DMA fetch FSM states shared with the video path
package pixie_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, LINE_END} state_t;
    localparam logic [15:0] START_ADDR = 16'h0900;
    localparam int BYTES_PER_LINE = 8;
    localparam int ROWS = 32;
    localparam int ROW_REPEAT = 4;
    localparam int BYTE_W = $clog2(BYTES_PER_LINE);
    localparam int ROW_W = $clog2(ROWS);
    localparam int REP_W = $clog2(ROW_REPEAT);
endpackage

// File: rtl/pixie_dma_fetch_if.sv
// pixie_dma_fetch_if: RAM read bus and DMA-out byte stream between fetch engine and video/memory
interface pixie_dma_fetch_if;
    logic        dma_req_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        sc_dma;
    modport master (input dma_req_n, mem_data, output mem_addr, mem_rd, data_out, data_valid, sc_dma);
    modport slave (output dma_req_n, mem_data, input mem_addr, mem_rd, data_out, data_valid, sc_dma);
endinterface

// File: rtl/pixie_dma_fetch.sv
// pixie_dma_fetch: fetches 8-byte display rows from RAM on DMA request, 4x row repeat, frame wrap and overrun blanking
module pixie_dma_fetch
    import pixie_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clk_enable,
    input  logic display_en,
    input  logic frame_start,
    pixie_dma_fetch_if.master bus,
    output logic frame_done,
    output logic overrun
);
    state_t state, state_nx;
    logic [15:0] row_base;
    logic [BYTE_W-1:0] byte_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic fs_q, fs_rise, complete, blank, start, last_byte, last_rep, last_row;

    assign fs_rise = frame_start & ~fs_q;
    assign start = display_en & ~bus.dma_req_n;
    assign last_byte = byte_cnt == BYTE_W'(BYTES_PER_LINE - 1);
    assign last_rep = rep_cnt == REP_W'(ROW_REPEAT - 1);
    assign last_row = row_cnt == ROW_W'(ROWS - 1);
    assign bus.mem_addr = row_base + 16'(byte_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else if (clk_enable) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? ADDR : IDLE;
            ADDR:     state_nx = DATA;
            DATA:     state_nx = last_byte ? LINE_END : (display_en ? ADDR : IDLE);
            default:  state_nx = IDLE;
        endcase
        if (fs_rise) state_nx = IDLE;
    end

    // Blank bursts keep the ADDR/DATA cadence but never touch RAM
    always_comb begin
        bus.mem_rd = state == ADDR && !blank;
        bus.sc_dma = state == ADDR || state == DATA;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= START_ADDR;
            byte_cnt <= '0;
            rep_cnt <= '0;
            row_cnt <= '0;
            fs_q <= 1'b0;
            complete <= 1'b0;
            blank <= 1'b0;
            overrun <= 1'b0;
            frame_done <= 1'b0;
            bus.data_out <= '0;
            bus.data_valid <= 1'b0;
        end else if (clk_enable) begin
            fs_q <= frame_start;
            frame_done <= 1'b0;
            bus.data_valid <= 1'b0;
            if (fs_rise) begin
                row_base <= START_ADDR;
                byte_cnt <= '0;
                rep_cnt <= '0;
                row_cnt <= '0;
                complete <= 1'b0;
                blank <= 1'b0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        blank <= complete;
                        overrun <= overrun | complete;
                    end
                    DATA: begin
                        bus.data_out <= blank ? 8'h00 : bus.mem_data;
                        bus.data_valid <= 1'b1;
                        byte_cnt <= (last_byte || !display_en) ? '0 : byte_cnt + 1'b1;
                    end
                    LINE_END: if (!blank) begin
                        rep_cnt <= last_rep ? '0 : rep_cnt + 1'b1;
                        if (last_rep) begin
                            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                            row_base <= last_row ? START_ADDR : row_base + 16'(BYTES_PER_LINE);
                            frame_done <= last_row;
                            complete <= last_row;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
